// File: rtl/irq_controller_if.sv
// irq_controller_if: bundles the peripheral/core-side signals of irq_controller.
//   irq_in      raw asynchronous interrupt lines (rising edge = event)
//   mask_we     mask register write strobe, mask_wdata new mask (1 = masked)
//   mask_q      current mask register, pending_q current pending register
//   int_req     interrupt request to the core, vector source index
//   int_ack     core acknowledge pulse, eoi end-of-interrupt pulse
//   busy        controller is requesting or servicing
interface irq_controller_if #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 5
);
  logic [NUM_IRQ-1:0] irq_in, mask_wdata, mask_q, pending_q;
  logic mask_we, int_req, int_ack, eoi, busy;
  logic [VEC_W-1:0] vector;
  modport master (
    output irq_in, mask_we, mask_wdata, int_ack, eoi,
    input  mask_q, pending_q, int_req, vector, busy
  );
  modport slave (
    input  irq_in, mask_we, mask_wdata, int_ack, eoi,
    output mask_q, pending_q, int_req, vector, busy
  );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: prioritised, maskable, edge-triggered interrupt controller driving the core's INT.
//   clk  rising-edge clock; rst asynchronous active-high reset
//   bus  irq_controller_if.slave (irq lines, mask register, req/ack/eoi handshake, vector, busy)
//   Define IRQ_NESTING_EN to allow a lower-index source to preempt the one in service.
module irq_controller #(
  parameter int NUM_IRQ     = 8,
  parameter int VEC_W       = 5,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  irq_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] dly_q, evt, pend_q, mask_q, insvc_q, insvc_d, cand, sel, clr;
  logic [VEC_W-1:0] vec_q, vec_d, win, low_svc;
  logic win_v;
  function automatic logic [VEC_W-1:0] lsb_idx(input logic [NUM_IRQ-1:0] v);
    lsb_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (v[i]) lsb_idx = VEC_W'(i);
  endfunction
  assign evt     = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign cand    = pend_q & ~mask_q;
  assign win     = lsb_idx(cand);
  assign win_v   = |cand;
  assign low_svc = lsb_idx(insvc_q);
  assign sel     = NUM_IRQ'(1) << vec_q;
`ifdef IRQ_NESTING_EN
  logic [NUM_IRQ-1:0] rest;
  assign rest = insvc_q & ~(NUM_IRQ'(1) << low_svc);
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q  <= '0;
      dly_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      insvc_q <= '0;
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
      dly_q   <= sync_q[SYNC_STAGES-1];
      pend_q  <= (pend_q & ~clr) | evt;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
      insvc_q <= insvc_d;
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  // The latched winner is only dropped when it becomes masked; with nesting the
  // controller then falls back to the innermost source still in service.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    insvc_d = insvc_q;
    clr     = '0;
    case (state_q)
      IDLE: if (win_v) begin
        state_d = REQ;
        vec_d   = win;
      end
      REQ: if (|(mask_q & sel)) begin
        state_d = |insvc_q ? SERVICE : IDLE;
        vec_d   = low_svc;
      end else if (bus.int_ack) begin
        clr     = sel;
        insvc_d = insvc_q | sel;
        state_d = SERVICE;
      end
      SERVICE: begin
`ifdef IRQ_NESTING_EN
        if (bus.eoi) begin
          insvc_d = rest;
          state_d = |rest ? SERVICE : IDLE;
          vec_d   = lsb_idx(rest);
        end else if (win_v && win < low_svc) begin
          state_d = REQ;
          vec_d   = win;
        end
`else
        if (bus.eoi) begin
          insvc_d = '0;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.mask_q    = mask_q;
  assign bus.pending_q = pend_q;
  assign bus.int_req   = state_q == REQ;
  assign bus.busy      = state_q != IDLE;
  assign bus.vector    = state_q == IDLE ? '0 : vec_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed stimulus checked every cycle against a behavioural model plus literal expectations.
module tb_irq_controller;
  localparam int N = 8;
  localparam int VW = 5;
  localparam int S = 2;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  irq_controller_if #(.NUM_IRQ(N), .VEC_W(VW)) bus ();
  irq_controller #(.NUM_IRQ(N), .VEC_W(VW), .SYNC_STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Model: mode 0 = idle, 1 = requesting, 2 = servicing. Raw samples are kept in a
  // history queue; an event is a 0->1 step seen S edges late.
  int m_mode, m_vec, m_w, m_ls;
  logic [N-1:0] m_pend, m_mask, m_isv, m_ev, m_clr;
  logic [N-1:0] hq[$];
  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_vec = 0; m_pend = '0; m_mask = '1; m_isv = '0;
      hq.delete();
      for (int k = 0; k < S + 2; k++) hq.push_back('0);
    end else begin
      hq.push_front(bus.irq_in);
      void'(hq.pop_back());
      m_ev = hq[S] & ~hq[S+1];
      m_clr = '0;
      m_w = lowest(m_pend & ~m_mask);
      m_ls = lowest(m_isv);
      case (m_mode)
        0: if (m_w >= 0) begin m_mode = 1; m_vec = m_w; end
        1: if (m_mask[m_vec]) begin
             if (m_isv != 0) begin m_mode = 2; m_vec = lowest(m_isv); end
             else m_mode = 0;
           end else if (bus.int_ack) begin
             m_clr[m_vec] = 1'b1; m_isv[m_vec] = 1'b1; m_mode = 2;
           end
        default: begin
`ifdef IRQ_NESTING_EN
          if (bus.eoi) begin
            m_isv[m_ls] = 1'b0;
            if (m_isv != 0) m_vec = lowest(m_isv); else m_mode = 0;
          end else if (m_w >= 0 && m_w < m_ls) begin
            m_mode = 1; m_vec = m_w;
          end
`else
          if (bus.eoi) begin m_isv = '0; m_mode = 0; end
`endif
        end
      endcase
      m_pend = (m_pend & ~m_clr) | m_ev;
      if (bus.mask_we) m_mask = bus.mask_wdata;
    end
  end

  always @(negedge clk)
    if (!rst) begin
      chk("model_pending", bus.pending_q, m_pend);
      chk("model_mask", bus.mask_q, m_mask);
      chk("model_int_req", bus.int_req, m_mode == 1);
      chk("model_busy", bus.busy, m_mode != 0);
      chk("model_vector", bus.vector, m_mode == 0 ? 0 : m_vec);
    end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr_mask(input logic [N-1:0] m);
    bus.mask_we = 1; bus.mask_wdata = m; tick(1); bus.mask_we = 0;
  endtask
  task automatic pulse_ack();
    bus.int_ack = 1; tick(1); bus.int_ack = 0;
  endtask
  task automatic pulse_eoi();
    bus.eoi = 1; tick(1); bus.eoi = 0;
  endtask

  initial begin
    bus.irq_in = '0; bus.mask_we = 0; bus.mask_wdata = '0; bus.int_ack = 0; bus.eoi = 0;
    tick(2);
    chk("rst_pending", bus.pending_q, 8'h00);
    chk("rst_mask", bus.mask_q, 8'hFF);
    chk("rst_int_req", bus.int_req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_vector", bus.vector, 0);
    rst = 0;
    // single source 3: latency, ack, ignored ack in service, eoi
    wr_mask(8'h00);
    bus.irq_in = 8'h08;
    tick(3);
    chk("t1_pending", bus.pending_q, 8'h08);
    chk("t1_noreq_yet", bus.int_req, 0);
    tick(1);
    chk("t1_int_req", bus.int_req, 1);
    chk("t1_vector", bus.vector, 3);
    tick(1);
    pulse_ack();
    chk("t1_ack_pending", bus.pending_q, 8'h00);
    chk("t1_ack_int_req", bus.int_req, 0);
    chk("t1_svc_vector", bus.vector, 3);
    pulse_ack();
    chk("t1_ign_ack_busy", bus.busy, 1);
    pulse_eoi();
    chk("t1_eoi_busy", bus.busy, 0);
    chk("t1_eoi_vector", bus.vector, 0);
    bus.irq_in = '0; tick(2);
    // sources 5 and 2 together: priority order
    bus.irq_in = 8'h24;
    tick(4);
    chk("t2_vector_first", bus.vector, 2);
    pulse_ack(); pulse_eoi();
    chk("t2_idle_after_eoi", bus.busy, 0);
    tick(1);
    chk("t2_int_req_second", bus.int_req, 1);
    chk("t2_vector_second", bus.vector, 5);
    bus.int_ack = 1; bus.eoi = 1; tick(1); bus.int_ack = 0; bus.eoi = 0;
    chk("t2_ackeoi_busy", bus.busy, 1);
    chk("t2_ackeoi_int_req", bus.int_req, 0);
    pulse_eoi();
    bus.irq_in = '0; tick(2);
    // masked pending is held, then requests after unmask
    wr_mask(8'hFF);
    bus.irq_in = 8'h02;
    tick(4);
    chk("t3_pending_masked", bus.pending_q, 8'h02);
    chk("t3_no_req", bus.int_req, 0);
    wr_mask(8'h00);
    chk("t3_req_not_yet", bus.int_req, 0);
    tick(1);
    chk("t3_int_req", bus.int_req, 1);
    chk("t3_vector", bus.vector, 1);
    pulse_ack(); pulse_eoi();
    bus.irq_in = '0; tick(2);
    // masking the latched winner in REQ drops the request
    bus.irq_in = 8'h10;
    tick(4);
    chk("t4_vector", bus.vector, 4);
    wr_mask(8'h10);
    chk("t4_still_req", bus.int_req, 1);
    tick(1);
    chk("t4_dropped", bus.int_req, 0);
    chk("t4_idle", bus.busy, 0);
    chk("t4_pending_kept", bus.pending_q, 8'h10);
    wr_mask(8'h00);
    tick(1);
    chk("t4_rereq_vector", bus.vector, 4);
    pulse_ack(); pulse_eoi();
    bus.irq_in = '0; tick(2);
    // ack of source 0 on the same edge as a new source 0 event
    bus.irq_in = 8'h01; tick(1);
    bus.irq_in = 8'h00; tick(1);
    bus.irq_in = 8'h01; tick(1);
    chk("t5_pending", bus.pending_q, 8'h01);
    tick(1);
    chk("t5_int_req", bus.int_req, 1);
    pulse_ack();
    chk("t5_pending_after_ack", bus.pending_q, 8'h01);
    chk("t5_svc", bus.busy, 1);
    pulse_eoi();
    chk("t5_idle", bus.busy, 0);
    tick(1);
    chk("t5_second_req", bus.int_req, 1);
    chk("t5_second_vector", bus.vector, 0);
    pulse_ack(); pulse_eoi();
    bus.irq_in = '0; tick(2);
    // higher-priority source arriving while 6 is in service
    bus.irq_in = 8'h40;
    tick(4);
    chk("t6_vector6", bus.vector, 6);
    pulse_ack();
    bus.irq_in = 8'h42;
    tick(4);
`ifdef IRQ_NESTING_EN
    chk("t6_preempt_req", bus.int_req, 1);
    chk("t6_preempt_vector", bus.vector, 1);
    pulse_ack();
    chk("t6_nested_vector", bus.vector, 1);
    pulse_eoi();
    chk("t6_back_vector", bus.vector, 6);
    chk("t6_back_busy", bus.busy, 1);
    chk("t6_back_int_req", bus.int_req, 0);
    pulse_eoi();
    chk("t6_idle", bus.busy, 0);
`else
    chk("t6_no_req", bus.int_req, 0);
    chk("t6_svc_vector", bus.vector, 6);
    pulse_eoi();
    chk("t6_idle", bus.busy, 0);
    tick(1);
    chk("t6_next_req", bus.int_req, 1);
    chk("t6_next_vector", bus.vector, 1);
    pulse_ack(); pulse_eoi();
`endif
    bus.irq_in = '0; tick(2);
    // reset mid-handshake
    bus.irq_in = 8'h04;
    tick(4);
    chk("t7_req_before_rst", bus.int_req, 1);
    #1 rst = 1;
    #1;
    chk("t7_rst_int_req", bus.int_req, 0);
    chk("t7_rst_busy", bus.busy, 0);
    chk("t7_rst_pending", bus.pending_q, 8'h00);
    chk("t7_rst_mask", bus.mask_q, 8'hFF);
    chk("t7_rst_vector", bus.vector, 0);
    tick(2);
    rst = 0;
    tick(6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised interrupt controller that drives the processor's single INT input.
- Generalises the one-bit INT line to NUM_IRQ prioritised, maskable, edge-triggered sources.
- Uses a request/acknowledge/end-of-interrupt handshake with the core and supplies a vector index.
- Sits between peripheral interrupt lines and the RISC core; `int_req` connects to the core's INT.

Parameters:
- NUM_IRQ, 8, number of interrupt sources (2..32); index 0 has highest priority.
- VEC_W, 5, width of vector output; must satisfy 2^VEC_W >= NUM_IRQ.
- SYNC_STAGES, 2, synchroniser depth on each `irq_in` bit (>= 2).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous active-high reset
- irq_in  input  NUM_IRQ  raw interrupt lines, asynchronous, rising edge = event
- mask_we  input  1  write strobe for mask register
- mask_wdata  input  NUM_IRQ  new mask value (1 = masked)
- mask_q  output  NUM_IRQ  current mask register
- pending_q  output  NUM_IRQ  current pending register
- int_req  output  1  interrupt request to core (INT)
- int_ack  input  1  core acknowledge, single-cycle pulse
- vector  output  VEC_W  index of the acknowledged/requested source
- eoi  input  1  end-of-interrupt pulse from core
- busy  output  1  high while in REQ or SERVICE

Behaviour:
- Reset (asynchronous, active-high) sets:
  - synchronisers, edge flops, `pending_q`, in-service register to 0;
  - `mask_q` to all ones;
  - state to IDLE;
  - `int_req`, `busy`, `vector` to 0.
- Synchronisation and edge detection:
  - each `irq_in` bit passes through SYNC_STAGES flops, then a delay flop;
  - event = synced & ~delayed.
- Pending register:
  - an event sets its pending bit regardless of mask;
  - a masked pending bit is retained but never requests.
- Latency: E = first edge sampling `irq_in[i]` high.
  - `pending_q[i]` = 1 after edge E+SYNC_STAGES.
  - `int_req` = 1 after edge E+SYNC_STAGES+1.
- Winner = lowest index i with `pending_q[i]` & ~`mask_q[i]`.
- IDLE:
  - if a winner exists, latch its index into `vector`, go to REQ, `int_req` = 1;
  - `vector` = 0 in IDLE.
- REQ:
  - `int_req` held high; the latched winner is not re-evaluated.
  - On `int_ack`: clear that pending bit, set its in-service bit, `int_req` = 0, go to SERVICE.
  - If the winner becomes masked before ack: `int_req` = 0, return to IDLE, pending bit kept.
- SERVICE:
  - `int_req` = 0; `vector` holds the serviced index.
  - On `eoi`: clear the in-service bit, go to IDLE; re-arbitration happens in IDLE the next cycle.
- Ignored inputs: `int_ack` outside REQ and `eoi` outside SERVICE have no effect.
- Simultaneous events on the same cycle:
  - pending clear (ack) and new event on the same bit: set wins, bit stays 1;
  - mask write and winner evaluation: new mask takes effect the following cycle;
  - `int_ack` and `eoi` together: each is handled only in its own state.
- `busy` = (state != IDLE).
- Reset mid-handshake: immediate return to reset values; outstanding pending and in-service state is lost.

Optional Feature:
- Macro: IRQ_NESTING_EN.
- Enabled:
  - the in-service register may hold multiple bits;
  - in SERVICE, an unmasked pending source with index strictly lower than the lowest set in-service bit raises `int_req` and moves to REQ (preemption), with `vector` = new winner;
  - `eoi` clears the lowest set in-service bit; if in-service remains nonzero, stay in SERVICE and `vector` = lowest remaining set bit, otherwise go to IDLE.
- Disabled:
  - at most one in-service bit;
  - no request while in SERVICE.

Test Plan:
- Reset, `mask_we` with `mask_wdata`=0x00, `irq_in[3]` rising sampled at edge 10 -> `pending_q`=0x08 after edge 12, `int_req`=1 and `vector`=3 after edge 13; ack at edge 15 -> `pending_q`=0x00, `int_req`=0; `eoi` at edge 18 -> `busy`=0.
- `irq_in[5]` and `irq_in[2]` rise together, mask 0x00 -> `vector`=2 first; after ack+eoi, `vector`=5 requested next.
- Mask 0xFF, `irq_in[1]` event -> `pending_q`=0x02, `int_req` stays 0; write mask 0x00 -> `int_req`=1, `vector`=1 two cycles after write.
- In REQ for channel 4, write mask 0x10 before ack -> `int_req` drops, state IDLE, `pending_q[4]`=1.
- Same-cycle ack of channel 0 and new `irq_in[0]` event -> `pending_q[0]`=1 after ack; second request follows eoi.
- IRQ_NESTING_EN: servicing channel 6, `irq_in[1]` event -> `int_req`=1, `vector`=1; ack; eoi -> `vector`=6, still SERVICE; eoi -> IDLE. Without macro -> no request until first eoi.
